// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative unsigned multiply/divide, one bit per cycle
// Define MULDIV_FLUSH_EN to add the flush input that aborts an operation in flight.
module muldiv_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef MULDIV_FLUSH_EN
  input  logic             flush,
`endif
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state, state_next;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opnd_q, hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic             fin_q;
  logic             kill, accept, div_zero;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] rem_diff, hi_step, lo_step;
  logic             rem_ge;

`ifdef MULDIV_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign accept   = (state == IDLE) && start && !kill;
  assign div_zero = op[1] && (b == '0);
  assign busy     = (state != IDLE);
  // FIN spans two cycles: the first writes result, the second presents done.
  assign done     = (state == FIN) && fin_q;

  // Multiply: hi accumulates, lo holds the shifting multiplier and low product.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {hi_q, lo_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
    if (op_q[1]) begin
      hi_step = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], rem_ge};
    end else begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = div_zero ? FIN : CALC;
      CALC:    if (cnt_q == '0) state_next = FIN;
      FIN:     if (fin_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill && (state != IDLE)) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      fin_q  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_next;
      fin_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_q  <= op;
          cnt_q <= CW'(WIDTH - 1);
          hi_q  <= '0;
          if (op[1]) begin
            opnd_q <= b;
            lo_q   <= a;
          end else begin
            opnd_q <= a;
            lo_q   <= b;
          end
          // Preload the divide-by-zero answers so FIN selects them like normal results.
          if (div_zero) begin
            hi_q <= a;
            lo_q <= '1;
          end
        end
        CALC: if (!kill) begin
          hi_q  <= hi_step;
          lo_q  <= lo_step;
          cnt_q <= cnt_q - CW'(1);
        end
        FIN: if (!kill && !fin_q) begin
          fin_q  <= 1'b1;
          result <= op_q[0] ? hi_q : lo_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;
  localparam int W = 64;
  localparam logic [W-1:0] ONES = '1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] result;

  int applied = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
`ifdef MULDIV_FLUSH_EN
    .flush  (flush),
`endif
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] e, input int l);
    vecs[i].op  = o;
    vecs[i].a   = x;
    vecs[i].b   = y;
    vecs[i].exp = e;
    vecs[i].lat = l;
  endtask

  // Accepted at edge T; returns 1ns after T with inputs scrambled.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = ~o;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
  endtask

  // Number of edges after T until done is seen, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, cnt;
    logic [W-1:0] r_first;

    set_vec(0,  2'b00, 64'd3, 64'd5, 64'd15, 65);
    set_vec(1,  2'b01, 64'd3, 64'd5, 64'd0, 65);
    set_vec(2,  2'b01, ONES, 64'd2, 64'd1, 65);
    set_vec(3,  2'b00, ONES, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    set_vec(4,  2'b10, 64'd100, 64'd7, 64'd14, 65);
    set_vec(5,  2'b11, 64'd100, 64'd7, 64'd2, 65);
    set_vec(6,  2'b10, 64'd42, 64'd0, ONES, 1);
    set_vec(7,  2'b11, 64'd42, 64'd0, 64'd42, 1);
    set_vec(8,  2'b01, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 65);
    set_vec(9,  2'b10, ONES, 64'h8000_0000_0000_0000, 64'd1, 65);
    set_vec(10, 2'b11, ONES, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 65);
    set_vec(11, 2'b11, 64'd5, 64'd9, 64'd5, 65);

    #1;
    check("reset_busy", W'(busy), '0);
    check("reset_done", W'(done), '0);
    check("reset_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), W'(busy), W'(1));
      wait_done(lat);
      check($sformatf("v%0d_latency", i), W'(lat), W'(vecs[i].lat));
      check($sformatf("v%0d_result", i), result, vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), W'(done), '0);
      check($sformatf("v%0d_idle", i), W'(busy), '0);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_held", i), result, vecs[i].exp);
    end

    // Reset in the middle of CALC
    issue(2'b00, 64'd3, 64'd5);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", W'(busy), '0);
    check("midrst_done", W'(done), '0);
    check("midrst_result", result, '0);
    #3;
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("midrst_no_done", W'(cnt), '0);

    // Start while busy and start during the done cycle are both ignored
    issue(2'b00, 64'd3, 64'd5);
    repeat (19) @(posedge clk);
    @(negedge clk);
    op = 2'b10; a = 64'd9; b = 64'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt = 0;
    lat = -1;
    r_first = '0;
    for (int n = 21; n <= 150; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        cnt++;
        if (lat < 0) begin
          lat = n;
          r_first = result;
          op = 2'b10; a = 64'd9; b = 64'd3; start = 1'b1;
        end
      end
    end
    start = 1'b0;
    check("busy_start_done_count", W'(cnt), W'(1));
    check("busy_start_latency", W'(lat), W'(65));
    check("busy_start_result", r_first, 64'd15);
    check("busy_start_final_result", result, 64'd15);
    check("busy_start_final_idle", W'(busy), '0);

`ifdef MULDIV_FLUSH_EN
    issue(2'b00, 64'd6, 64'd7);
    repeat (29) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_idle", W'(busy), '0);
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("flush_no_done", W'(cnt), '0);
    check("flush_result_kept", result, 64'd15);
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 2'b00; a = 64'd2; b = 64'd2;
    @(posedge clk);
    #1;
    flush = 1'b0; start = 1'b0;
    check("flush_beats_start", W'(busy), '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end
endmodule
